// File: rtl/chan_arb_fifo.sv
// Multi-channel ingress buffer: one private FIFO per producer, merged by a
// round-robin arbiter onto a single registered valid/ready stream tagged with its channel.
module chan_arb_fifo #(
  parameter  int CHANNELS = 2,
  parameter  int WIDTH    = 2,
  parameter  int DEPTH    = 4,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LW       = $clog2(DEPTH + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS-1:0]       i_valid,
  output logic [CHANNELS-1:0]       o_ready,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [WIDTH-1:0]          o_data,
  output logic [CW-1:0]             o_chan,
  output logic [CHANNELS*LW-1:0]    o_level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0]    r_mem   [CHANNELS][DEPTH];
  logic [PW-1:0]       r_wrPtr [CHANNELS];
  logic [PW-1:0]       r_rdPtr [CHANNELS];
  logic [LW-1:0]       r_level [CHANNELS];
  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [CW-1:0]       r_chan;
  logic [CW-1:0]       r_rrPtr;

  logic [CHANNELS-1:0] w_empty;
  logic [CHANNELS-1:0] w_full;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_pop;
  logic                w_load;
  logic                w_grantValid;
  logic [CW-1:0]       w_grant;
  logic [CW-1:0]       w_idx;

  // Pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_empty = '0;
    w_full  = '0;
    w_push  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_empty[c] = (r_level[c] == LW'(0));
      w_full[c]  = (r_level[c] == LW'(DEPTH));
      w_push[c]  = i_valid[c] && !w_full[c];
    end
  end

  // Scan from the RR pointer; emptiness is pre-write, so no same-cycle bypass
  always_comb begin
    w_load       = !r_valid || i_ready;
    w_grantValid = 1'b0;
    w_grant      = '0;
    w_idx        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_idx = CW'((int'(r_rrPtr) + i) % CHANNELS);
      if (!w_grantValid && !w_empty[w_idx]) begin
        w_grantValid = 1'b1;
        w_grant      = w_idx;
      end
    end
    w_pop = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_pop[c] = w_load && w_grantValid && (w_grant == CW'(c));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_wrPtr[c] <= '0;
        r_rdPtr[c] <= '0;
        r_level[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_push[c]) r_wrPtr[c] <= nextPtr(r_wrPtr[c]);
        if (w_pop[c])  r_rdPtr[c] <= nextPtr(r_rdPtr[c]);
        if (w_push[c] && !w_pop[c]) begin
          r_level[c] <= r_level[c] + LW'(1);
        end else if (!w_push[c] && w_pop[c]) begin
          r_level[c] <= r_level[c] - LW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_push[c]) r_mem[c][r_wrPtr[c]] <= i_data[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_rrPtr <= '0;
    end else if (w_load) begin
      if (w_grantValid) begin
        r_valid <= 1'b1;
        r_data  <= r_mem[w_grant][r_rdPtr[w_grant]];
        r_chan  <= w_grant;
        r_rrPtr <= (w_grant == CW'(CHANNELS - 1)) ? '0 : w_grant + CW'(1);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_chan  = r_chan;
  assign o_ready = ~w_full;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_level
    assign o_level[c*LW +: LW] = r_level[c];
  end

endmodule

// File: tb/tb_chan_arb_fifo.sv
// Self-checking bench for chan_arb_fifo: a queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_chan_arb_fifo;

  localparam int CH = 2;
  localparam int W  = 2;
  localparam int D  = 4;
  localparam int CW = 1;
  localparam int LW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CH-1:0]   valid = '0;
  logic [CH-1:0]   readyOut;
  logic [CH*W-1:0] data = '0;
  logic            oValid;
  logic            iReady = 1'b0;
  logic [W-1:0]    oData;
  logic [CW-1:0]   oChan;
  logic [CH*LW-1:0] oLevel;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mq [CH][$];
  bit           mValid = 1'b0;
  logic [W-1:0] mData = '0;
  int           mChan = 0;
  int           mRr = 0;
  bit           modelLive = 1'b0;

  always #5 clk = ~clk;

  chan_arb_fifo #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .o_ready (readyOut),
    .i_data  (data),
    .o_valid (oValid),
    .i_ready (iReady),
    .o_data  (oData),
    .o_chan  (oChan),
    .o_level (oLevel)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] v, input logic [CH*W-1:0] d,
                               input logic r, input logic rs);
    valid  = v;
    data   = d;
    iReady = r;
    rst    = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic int lvl(input int c);
    return int'(oLevel[c*LW +: LW]);
  endfunction

  // Model: FIFOs as queues; full-only acceptance and pre-write emptiness
  always @(posedge clk) begin
    bit accept [CH];
    int g;
    int idx;
    if (rst) begin
      for (int c = 0; c < CH; c++) mq[c].delete();
      mValid    = 1'b0;
      mData     = '0;
      mChan     = 0;
      mRr       = 0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      for (int c = 0; c < CH; c++) accept[c] = valid[c] && (mq[c].size() < D);
      if (!mValid || iReady) begin
        g = -1;
        for (int i = 0; i < CH; i++) begin
          idx = (mRr + i) % CH;
          if (g < 0 && mq[idx].size() > 0) g = idx;
        end
        if (g >= 0) begin
          mData  = mq[g].pop_front();
          mChan  = g;
          mValid = 1'b1;
          mRr    = (g + 1) % CH;
        end else begin
          mValid = 1'b0;
        end
      end
      for (int c = 0; c < CH; c++) begin
        if (accept[c]) mq[c].push_back(data[c*W +: W]);
      end
    end
  end

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("model_valid", int'(oValid), int'(mValid));
      if (mValid) begin
        checkOutput("model_data", int'(oData), int'(mData));
        checkOutput("model_chan", int'(oChan), mChan);
      end
      for (int c = 0; c < CH; c++) begin
        checkOutput("model_level", lvl(c), mq[c].size());
        checkOutput("model_ready", int'(readyOut[c]), (mq[c].size() < D) ? 1 : 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int chanSeq [6] = '{0, 1, 0, 1, 0, 1};
    int dataSeq [6] = '{1, 2, 2, 3, 3, 1};
    int ch1Words [5] = '{2, 3, 1, 2, 0};
    logic [CH*W-1:0] dv;

    // Reset state
    applyStimulus(2'b00, 4'h0, 1'b0, 1'b1);
    checkOutput("rst_valid", int'(oValid), 0);
    checkOutput("rst_data", int'(oData), 0);
    checkOutput("rst_chan", int'(oChan), 0);
    checkOutput("rst_ready", int'(readyOut), 3);
    checkOutput("rst_level", int'(oLevel), 0);

    // Latency: no bypass in the acceptance cycle, visible one cycle later
    applyStimulus(2'b01, 4'b0010, 1'b1, 1'b0);
    checkOutput("lat_nobypass", int'(oValid), 0);
    applyStimulus(2'b00, 4'h0, 1'b1, 1'b0);
    checkOutput("lat_valid", int'(oValid), 1);
    checkOutput("lat_data", int'(oData), 2);
    checkOutput("lat_chan", int'(oChan), 0);
    applyStimulus(2'b00, 4'h0, 1'b1, 1'b0);
    checkOutput("lat_drain", int'(oValid), 0);

    // Occupy the output stage with a CH0 word, then overfill CH1
    applyStimulus(2'b01, 4'b0001, 1'b0, 1'b0);
    applyStimulus(2'b00, 4'h0, 1'b0, 1'b0);
    checkOutput("full_hold_valid", int'(oValid), 1);
    for (int k = 0; k < 5; k++) begin
      dv = {2'(ch1Words[k]), 2'b00};
      applyStimulus(2'b10, dv, 1'b0, 1'b0);
    end
    checkOutput("full_ready", int'(readyOut), 1);
    checkOutput("full_level", lvl(1), 4);

    // Backpressure: output stable, no pops
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b00, 4'h0, 1'b0, 1'b0);
      checkOutput("bp_data", int'(oData), 1);
      checkOutput("bp_chan", int'(oChan), 0);
      checkOutput("bp_level", lvl(1), 4);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, 4'h0, 1'b1, 1'b0);
      checkOutput("drain_chan", int'(oChan), 1);
      checkOutput("drain_data", int'(oData), ch1Words[k]);
    end
    applyStimulus(2'b00, 4'h0, 1'b1, 1'b0);
    checkOutput("drop_fifth", int'(oValid), 0);

    // Fairness after reset
    applyStimulus(2'b00, 4'h0, 1'b0, 1'b1);
    applyStimulus(2'b11, {2'd2, 2'd1}, 1'b0, 1'b0);
    applyStimulus(2'b11, {2'd3, 2'd2}, 1'b0, 1'b0);
    applyStimulus(2'b11, {2'd1, 2'd3}, 1'b0, 1'b0);
    checkOutput("rr_chan0", int'(oChan), chanSeq[0]);
    checkOutput("rr_data0", int'(oData), dataSeq[0]);
    for (int k = 1; k < 6; k++) begin
      applyStimulus(2'b00, 4'h0, 1'b1, 1'b0);
      checkOutput("rr_chan", int'(oChan), chanSeq[k]);
      checkOutput("rr_data", int'(oData), dataSeq[k]);
    end
    applyStimulus(2'b00, 4'h0, 1'b1, 1'b0);
    checkOutput("rr_empty", int'(oValid), 0);

    // Push/pop pairs across pointer wrap
    for (int k = 0; k < 10; k++) begin
      dv = {2'b00, 2'(k % 4)};
      applyStimulus(2'b01, dv, 1'b1, 1'b0);
      if (k >= 1) checkOutput("wrap_data", int'(oData), (k - 1) % 4);
    end
    applyStimulus(2'b01, 4'b0010, 1'b0, 1'b0);
    checkOutput("wrap_level2", lvl(0), 2);

    // Mid-operation reset discards everything
    applyStimulus(2'b00, 4'h0, 1'b1, 1'b1);
    checkOutput("mid_rst_level", lvl(0), 0);
    checkOutput("mid_rst_valid", int'(oValid), 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b00, 4'h0, 1'b1, 1'b0);
      checkOutput("mid_rst_quiet", int'(oValid), 0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
